// File: rtl/ped_pkg.sv
// Purpose: shared channel state type and default timing constants for the pedestrian request unit.
// Latency: none (types and constants only).
// Backpressure: none.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        WALK    = 2'd2,
        FLASH   = 2'd3
    } ped_state_t;

    // Default cycle counts at a 100 Hz clock
    localparam int DEF_DEBOUNCE_CYCLES = 5;     // 50 ms
    localparam int DEF_WALK_CYCLES     = 1000;  // 10 s
    localparam int DEF_FLASH_CYCLES    = 500;   // 5 s
    localparam int DEF_FLASH_HALF      = 25;    // blink half-period

    // Phase timer width; wide enough for the longest phase without wrapping
    localparam int PHASE_W = 11;

endpackage

// File: rtl/ped_request_unit_if.sv
// Purpose: groups the two pedestrian channels' button, grant and lamp/request signals.
// Latency: none (wiring only).
// Backpressure: none; ack is a single-cycle grant pulse, req is held until granted.
interface ped_request_unit_if;

    logic btn1;
    logic btn2;
    logic ack1;
    logic ack2;
    logic req1;
    logic req2;
    logic walk1;
    logic walk2;
    logic dontwalk1;
    logic dontwalk2;

    // Side that drives buttons and grants (buttons + traffic-light controller)
    modport master (
        output btn1, btn2, ack1, ack2,
        input  req1, req2, walk1, walk2, dontwalk1, dontwalk2
    );

    // The request unit itself
    modport slave (
        input  btn1, btn2, ack1, ack2,
        output req1, req2, walk1, walk2, dontwalk1, dontwalk2
    );

endinterface

// File: rtl/ped_channel.sv
// Purpose: one pedestrian crossing channel: btn synchronizer, debouncer, IDLE/PENDING/WALK/FLASH FSM, phase timer.
// Latency: req rises DEBOUNCE_CYCLES+2 edges after btn is first sampled high; all outputs registered.
// Backpressure: req held until ack; presses in PENDING/WALK and acks outside PENDING are dropped.
module ped_channel
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
    parameter int FLASH_CYCLES    = DEF_FLASH_CYCLES,
    parameter int FLASH_HALF      = DEF_FLASH_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic ack,
    output logic req,
    output logic walk,
    output logic dontwalk
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] WALK_LAST  = PHASE_W'(WALK_CYCLES - 1);
    localparam logic [PHASE_W-1:0] FLASH_LAST = PHASE_W'(FLASH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(FLASH_HALF - 1);

    logic               sync_q1;
    logic               sync_q2;
    logic               deb_lvl;
    logic [DB_W-1:0]    db_cnt;
    logic               press;
    ped_state_t         state;
    logic [PHASE_W-1:0] phase_cnt;
    logic [PHASE_W-1:0] blink_cnt;
    logic               flash_latch;

    function automatic logic [PHASE_W-1:0] sat_inc(input logic [PHASE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // The press fires on the sample that completes the stable run, so the FSM
    // reacts in the same edge the debounced level flips (no extra cycle).
    assign press = sync_q2 && !deb_lvl && (db_cnt == DB_LAST);

    // Debouncer: count consecutive samples differing from the accepted level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_lvl <= 1'b0;
            db_cnt  <= '0;
        end else if (sync_q2 == deb_lvl) begin
            db_cnt  <= '0;
        end else if (db_cnt == DB_LAST) begin
            deb_lvl <= sync_q2;
            db_cnt  <= '0;
        end else begin
            db_cnt  <= db_cnt + 1'b1;
        end
    end

    // Channel FSM with phase timer, blink timer, FLASH press latch and registered lamps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            blink_cnt   <= '0;
            flash_latch <= 1'b0;
            req         <= 1'b0;
            walk        <= 1'b0;
            dontwalk    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        state     <= PENDING;
                        phase_cnt <= '0;
                        req       <= 1'b1;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end
                PENDING: begin
                    if (ack) begin
                        state     <= WALK;
                        phase_cnt <= '0;
                        req       <= 1'b0;
                        walk      <= 1'b1;
                        dontwalk  <= 1'b0;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end
                WALK: begin
                    if (phase_cnt == WALK_LAST) begin
                        state       <= FLASH;
                        phase_cnt   <= '0;
                        blink_cnt   <= '0;
                        flash_latch <= 1'b0;
                        walk        <= 1'b0;
                        dontwalk    <= 1'b1;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end
                FLASH: begin
                    if (phase_cnt == FLASH_LAST) begin
                        // a press on the final FLASH cycle still counts as latched
                        state       <= (flash_latch || press) ? PENDING : IDLE;
                        req         <= flash_latch || press;
                        dontwalk    <= 1'b1;
                        phase_cnt   <= '0;
                        flash_latch <= 1'b0;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                        if (press) begin
                            flash_latch <= 1'b1;
                        end
                        if (blink_cnt == HALF_LAST) begin
                            blink_cnt <= '0;
                            dontwalk  <= ~dontwalk;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    req      <= 1'b0;
                    walk     <= 1'b0;
                    dontwalk <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ped_request_unit.sv
// Purpose: two identical, independent pedestrian crossing channels.
// Latency: as ped_channel (req DEBOUNCE_CYCLES+2 edges after btn rise, outputs registered).
// Backpressure: per channel, req held until ackN; no cross-channel interaction.
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
    parameter int FLASH_CYCLES    = DEF_FLASH_CYCLES,
    parameter int FLASH_HALF      = DEF_FLASH_HALF
) (
    input logic               clk,
    input logic               rst,
    ped_request_unit_if.slave bus
);

    ped_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .WALK_CYCLES     (WALK_CYCLES),
        .FLASH_CYCLES    (FLASH_CYCLES),
        .FLASH_HALF      (FLASH_HALF)
    ) u_ch1 (
        .clk      (clk),
        .rst      (rst),
        .btn      (bus.btn1),
        .ack      (bus.ack1),
        .req      (bus.req1),
        .walk     (bus.walk1),
        .dontwalk (bus.dontwalk1)
    );

    ped_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .WALK_CYCLES     (WALK_CYCLES),
        .FLASH_CYCLES    (FLASH_CYCLES),
        .FLASH_HALF      (FLASH_HALF)
    ) u_ch2 (
        .clk      (clk),
        .rst      (rst),
        .btn      (bus.btn2),
        .ack      (bus.ack2),
        .req      (bus.req2),
        .walk     (bus.walk2),
        .dontwalk (bus.dontwalk2)
    );

endmodule

// File: tb/tb_ped_request_unit.sv
// Purpose: self-checking bench for ped_request_unit against a behavioural per-channel model.
// Latency: inputs driven on the falling edge, outputs compared on the following falling edge.
// Backpressure: none; bench drives btn/ack freely.
module tb_ped_request_unit;

    localparam int D  = 5;
    localparam int WC = 1000;
    localparam int FC = 500;
    localparam int FH = 25;

    localparam int M_IDLE  = 0;
    localparam int M_PEND  = 1;
    localparam int M_WALK  = 2;
    localparam int M_FLASH = 3;

    localparam logic [63:0] WIN_MASK = (64'd1 << D) - 64'd1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ped_request_unit_if ifc();

    ped_request_unit #(
        .DEBOUNCE_CYCLES (D),
        .WALK_CYCLES     (WC),
        .FLASH_CYCLES    (FC),
        .FLASH_HALF      (FH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: state name, time spent in phase, FLASH latch,
    // accepted button level and raw btn history (bit0 = newest sample).
    int          m_state[2];
    int          m_t[2];
    bit          m_latch[2];
    bit          m_deb[2];
    logic [63:0] m_hist[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_state[c] = M_IDLE;
            m_t[c]     = 0;
            m_latch[c] = 1'b0;
            m_deb[c]   = 1'b0;
            m_hist[c]  = '0;
        end
    endtask

    task automatic model_chan(input int c, input logic b, input logic a);
        logic [63:0] win;
        bit          press;
        m_hist[c] = {m_hist[c][62:0], b};
        // two-stage synchronizer delay, then the last D samples decide the level
        win   = (m_hist[c] >> 2) & WIN_MASK;
        press = 1'b0;
        if (!m_deb[c] && win == WIN_MASK) begin
            m_deb[c] = 1'b1;
            press    = 1'b1;
        end else if (m_deb[c] && win == 64'd0) begin
            m_deb[c] = 1'b0;
        end
        case (m_state[c])
            M_IDLE: if (press) m_state[c] = M_PEND;
            M_PEND: if (a) begin m_state[c] = M_WALK; m_t[c] = 0; end
            M_WALK: begin
                if (m_t[c] == WC - 1) begin
                    m_state[c] = M_FLASH; m_t[c] = 0; m_latch[c] = 1'b0;
                end else begin
                    m_t[c]++;
                end
            end
            default: begin
                if (press) m_latch[c] = 1'b1;
                if (m_t[c] == FC - 1) begin
                    m_state[c] = m_latch[c] ? M_PEND : M_IDLE;
                    m_latch[c] = 1'b0;
                    m_t[c]     = 0;
                end else begin
                    m_t[c]++;
                end
            end
        endcase
    endtask

    // {req, walk, dontwalk} expected from the model state
    function automatic logic [2:0] exp_chan(input int c);
        case (m_state[c])
            M_IDLE:  return 3'b001;
            M_PEND:  return 3'b101;
            M_WALK:  return 3'b010;
            default: return {2'b00, ((m_t[c] / FH) % 2 == 0)};
        endcase
    endfunction

    function automatic logic [5:0] expected();
        return {exp_chan(1), exp_chan(0)};
    endfunction

    function automatic logic [5:0] observed();
        return {ifc.req2, ifc.walk2, ifc.dontwalk2, ifc.req1, ifc.walk1, ifc.dontwalk1};
    endfunction

    // Advance one clock: the model sees the same inputs as the DUT at the rising edge
    task automatic cyc();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            model_chan(0, ifc.btn1, ifc.ack1);
            model_chan(1, ifc.btn2, ifc.ack2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifc.btn1 = 1'b0; ifc.btn2 = 1'b0; ifc.ack1 = 1'b0; ifc.ack2 = 1'b0;
        model_reset();
        cyc(); cyc();
        vectors++;
        if (observed() !== 6'b001_001) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b", observed(), 6'b001_001);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL reset_release[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_clean_press();
        int rise_edge = -1;
        ifc.btn1 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (ifc.req1 === 1'b1 && rise_edge < 0) rise_edge = n;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL clean_press_model[%0d]: got %b expected %b", n, observed(), expected());
            end
        end
        vectors++;
        if (rise_edge !== D + 2) begin
            miscompares++;
            $display("FAIL clean_press_req_edge: got %0d expected %0d", rise_edge, D + 2);
        end
        vectors++;
        if (ifc.req2 !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_press_req2: got %b expected 0", ifc.req2);
        end
        ifc.btn1 = 1'b0;
    endtask

    task automatic test_full_cycle();
        int   walk_cycles = 0;
        int   dw_changes  = 0;
        logic prev_walk   = 1'b0;
        logic prev_dw     = 1'b0;
        ifc.ack1 = 1'b1;
        cyc();
        ifc.ack1 = 1'b0;
        vectors++;
        if ({ifc.req1, ifc.walk1, ifc.dontwalk1} !== 3'b010) begin
            miscompares++;
            $display("FAIL ack_to_walk: got %b expected 010", {ifc.req1, ifc.walk1, ifc.dontwalk1});
        end
        for (int i = 0; i < WC + FC + 60; i++) begin
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL full_cycle_model[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (walk_cycles > 0 && !ifc.walk1 && !prev_walk && ifc.dontwalk1 !== prev_dw) dw_changes++;
            if (ifc.walk1) walk_cycles++;
            prev_walk = ifc.walk1;
            prev_dw   = ifc.dontwalk1;
            cyc();
        end
        vectors++;
        if (walk_cycles !== WC) begin
            miscompares++;
            $display("FAIL walk_length: got %0d expected %0d", walk_cycles, WC);
        end
        vectors++;
        if (dw_changes !== FC / FH) begin
            miscompares++;
            $display("FAIL flash_blinks: got %0d expected %0d", dw_changes, FC / FH);
        end
        vectors++;
        if (observed() !== 6'b001_001) begin
            miscompares++;
            $display("FAIL after_flash_idle: got %b expected %b", observed(), 6'b001_001);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 30; i++) begin
            ifc.btn1 = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
            cyc();
            vectors++;
            if (ifc.req1 !== 1'b0 || observed() !== expected()) begin
                miscompares++;
                $display("FAIL bounce[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_ignored_events();
        // ack while IDLE
        ifc.ack1 = 1'b1;
        cyc();
        ifc.ack1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (observed() !== 6'b001_001) begin
                miscompares++;
                $display("FAIL ack_in_idle[%0d]: got %b expected %b", i, observed(), 6'b001_001);
            end
            cyc();
        end
        // press, release, grant, then press during WALK
        ifc.btn1 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) ifc.btn1 = 1'b0;
            if (i == 20) ifc.ack1 = 1'b1;
            if (i == 21) ifc.ack1 = 1'b0;
            cyc();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL grant_seq[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
        for (int i = 0; i < 200; i++) begin
            ifc.btn1 = (i >= 100 && i < 112);
            cyc();
            vectors++;
            if ({ifc.req1, ifc.walk1, ifc.dontwalk1} !== 3'b010 || observed() !== expected()) begin
                miscompares++;
                $display("FAIL press_in_walk[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_flash_press();
        int guard = 0;
        while (ifc.walk1 === 1'b1 && guard < WC) begin
            cyc();
            guard++;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL walk_to_flash[%0d]: got %b expected %b", guard, observed(), expected());
            end
        end
        vectors++;
        if (ifc.walk1 !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_end_timeout: got walk1=%b expected 0", ifc.walk1);
        end
        for (int i = 0; i < FC; i++) begin
            ifc.btn1 = (i >= 100 && i < 112);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL flash_press[%0d]: got %b expected %b", i, observed(), expected());
            end
            cyc();
        end
        vectors++;
        if ({ifc.req1, ifc.walk1, ifc.dontwalk1} !== 3'b101) begin
            miscompares++;
            $display("FAIL flash_to_pending: got %b expected 101", {ifc.req1, ifc.walk1, ifc.dontwalk1});
        end
    endtask

    task automatic test_reset_mid_walk();
        int rise_edge = -1;
        ifc.ack1 = 1'b1;
        cyc();
        ifc.ack1 = 1'b0;
        for (int i = 0; i < 399; i++) cyc();
        vectors++;
        if (observed() !== expected() || ifc.walk1 !== 1'b1) begin
            miscompares++;
            $display("FAIL walk_400: got %b expected %b", observed(), expected());
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({ifc.req1, ifc.walk1, ifc.dontwalk1} !== 3'b001 || observed() !== expected()) begin
            miscompares++;
            $display("FAIL async_reset_walk: got %b expected %b", observed(), expected());
        end
        cyc(); cyc();
        rst = 1'b1;
        ifc.btn1 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            if (ifc.req1 === 1'b1 && rise_edge < 0) rise_edge = n;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL post_reset_model[%0d]: got %b expected %b", n, observed(), expected());
            end
        end
        ifc.btn1 = 1'b0;
        vectors++;
        if (rise_edge !== D + 2) begin
            miscompares++;
            $display("FAIL post_reset_req_edge: got %0d expected %0d", rise_edge, D + 2);
        end
    endtask

    task automatic test_random();
        int   run_len[2];
        logic bval[2];
        run_len[0] = 1; run_len[1] = 1;
        bval[0] = 1'b0; bval[1] = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            for (int c = 0; c < 2; c++) begin
                run_len[c]--;
                if (run_len[c] == 0) begin
                    bval[c]    = ~bval[c];
                    run_len[c] = int'($urandom_range(1, 15));
                end
            end
            ifc.btn1 = bval[0];
            ifc.btn2 = bval[1];
            ifc.ack1 = ($urandom_range(0, 39) == 0);
            ifc.ack2 = ($urandom_range(0, 39) == 0);
            cyc();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %b expected %b", i, observed(), expected());
            end
            vectors++;
            if ((ifc.walk1 && ifc.dontwalk1) || (ifc.walk2 && ifc.dontwalk2)) begin
                miscompares++;
                $display("FAIL lamp_exclusive[%0d]: got %b expected no walk+dontwalk", i, observed());
            end
        end
        ifc.btn1 = 1'b0; ifc.btn2 = 1'b0; ifc.ack1 = 1'b0; ifc.ack2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_full_cycle();
        test_bounce();
        test_ignored_events();
        test_flash_press();
        test_reset_mid_walk();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ped_request_unit.md
PED_REQUEST_UNIT -- requirements
Module: ped_request_unit

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5, is the number of consecutive stable synchronized samples (50 ms at 100 Hz) needed to accept a button level.
REQ-002 Parameter WALK_CYCLES, default 1000, is the WALK phase length (10 s).
REQ-003 Parameter FLASH_CYCLES, default 500, is the flashing don't-walk phase length (5 s).
REQ-004 Parameter FLASH_HALF, default 25, is the half-period of the flash blink in cycles.
REQ-005 clk  input  1  system clock, 100 Hz, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 btn1, btn2  input  1 each  raw pedestrian push-buttons; asynchronous and bouncing; high = pressed.
REQ-008 ack1, ack2  input  1 each  single-cycle pulse from the traffic-light controller granting the crossing.
REQ-009 req1, req2  output  1 each  pending crossing request to the controller.
REQ-010 walk1, walk2  output  1 each  walk lamp.
REQ-011 dontwalk1, dontwalk2  output  1 each  don't-walk lamp, steady or blinking.

Function
REQ-012 Channels 1 and 2 SHALL be identical and fully independent; a channel uses only its own btnN, ackN and outputs.
REQ-013 Each btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples at the new level; any differing sample restarts the count.
REQ-015 A press event is a 0->1 transition of the debounced level; holding the button SHALL NOT generate further events.
REQ-016 For a clean btn rise, req SHALL assert exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples btn high.
REQ-017 Each channel SHALL have four states: IDLE, PENDING, WALK and FLASH.
REQ-018 IDLE SHALL go to PENDING on a press event.
REQ-019 PENDING SHALL go to WALK on ack.
REQ-020 WALK SHALL go to FLASH after WALK_CYCLES cycles.
REQ-021 FLASH SHALL go to PENDING after FLASH_CYCLES cycles if a press was latched during FLASH, and to IDLE otherwise.
REQ-022 The req output SHALL be 1 in PENDING and 0 in every other state.
REQ-023 The walk output SHALL be 1 in WALK and 0 in every other state.
REQ-024 The dontwalk output SHALL be 1 in IDLE and PENDING and 0 in WALK.
REQ-025 In FLASH, dontwalk SHALL start at 1 and toggle every FLASH_HALF cycles.
REQ-026 walk and dontwalk SHALL never both be 1.
REQ-027 All outputs SHALL be registered; there is no combinational path from any input to any output.
REQ-028 Press events in PENDING and WALK SHALL be ignored.
REQ-029 A press event in FLASH SHALL set a one-bit latch that is cleared on leaving FLASH.
REQ-030 An ack in IDLE, WALK or FLASH SHALL be ignored.
REQ-031 A press event in the same cycle as an accepted ack SHALL be ignored.
REQ-032 The phase counter SHALL be 11 bits, load 0 on every state entry, and saturate; it SHALL never wrap inside a phase.

Reset
REQ-033 While rst=0, every channel SHALL be in IDLE, with synchronizers, debounce state, counters and latches cleared.
REQ-034 While rst=0, req=0, walk=0 and dontwalk=1 on both channels.
REQ-035 Reset asserted mid-WALK or mid-FLASH SHALL take the outputs to their reset values immediately (asynchronously).
REQ-036 After rst deasserts, a button already held high SHALL produce a press event once it has been debounced.

Structure
REQ-037 Package ped_pkg SHALL hold the channel state typedef (IDLE, PENDING, WALK, FLASH) and the default cycle-count constants.
REQ-038 Sub-module ped_channel SHALL implement one complete channel (synchronizer, debouncer, FSM, timer).
REQ-039 ped_request_unit SHALL instantiate ped_channel twice and contain no other logic.

Verification
REQ-040 Clean press: btn1 held high for 10 cycles -> req1 rises at edge 7; req2 stays 0.
REQ-041 Bounce: btn1 toggling every 2 cycles for 20 cycles, then low -> req1 stays 0.
REQ-042 Full cycle: press, then ack1 pulse 3 cycles after req1 rises -> req1=0 and walk1=1 for exactly 1000 cycles; then dontwalk1 blinks 25 on / 25 off for 500 cycles; then IDLE with dontwalk1=1.
REQ-043 Press during FLASH -> channel returns to PENDING (req1=1) at FLASH end.
REQ-044 Press during WALK, or ack1 in IDLE -> no state change.
REQ-045 rst pulsed low at WALK cycle 400 -> walk1=0 and dontwalk1=1 at once; the next press works normally.
